// File: rtl/arvi_mem_responder.sv
// rtl/arvi_mem_responder.sv - word-addressed bus responder with wait states, stall watchdog and range check
module arvi_mem_responder #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 1,
  parameter int MAX_STALL = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_bus_en,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_byte_en,
  input  logic                i_stall,
  output logic                o_ack,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_err,
  output logic                o_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SC_W  = $clog2(MAX_STALL + 1);
  localparam logic [SC_W-1:0] STALL_LIM = SC_W'(MAX_STALL);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_n;
  logic [3:0]              wait_cnt, wait_cnt_n;
  logic [SC_W-1:0]         stall_cnt, stall_cnt_n;
  logic                    capture, commit;
  logic                    wr_q, in_range_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [BE_W-1:0]         be_q;
  logic [ADDR_W-OFF_W-1:0] word_idx;
  logic                    req_in_range;
  logic [DATA_W-1:0]       mem [DEPTH];

  assign word_idx     = i_addr[ADDR_W-1:OFF_W];
  // Any set bit above the index field means the word lies beyond DEPTH.
  assign req_in_range = (word_idx >> IDX_W) == '0;
  assign o_busy       = (state != S_IDLE);

  generate
    if (OFF_W > 0) begin : g_lane_bits
      logic unused_lane_bits;
      assign unused_lane_bits = ^i_addr[OFF_W-1:0];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      stall_cnt  <= '0;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      o_ack      <= 1'b0;
      o_err      <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      stall_cnt <= stall_cnt_n;
      if (capture) begin
        wr_q       <= i_wr_en;
        in_range_q <= req_in_range;
        idx_q      <= word_idx[IDX_W-1:0];
        wdata_q    <= i_wr_data;
        be_q       <= i_byte_en;
      end
      o_ack     <= commit;
      o_err     <= commit && !in_range_q;
      o_rd_data <= (commit && !wr_q && in_range_q) ? mem[idx_q] : '0;
    end
  end

  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    stall_cnt_n = stall_cnt;
    capture     = 1'b0;
    commit      = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_bus_en) begin
          state_n     = S_WAIT;
          capture     = 1'b1;
          wait_cnt_n  = 4'(LATENCY);
          stall_cnt_n = '0;
        end
      end
      S_WAIT: begin
        // Once MAX_STALL consecutive stalls are honoured the stall input is ignored for a cycle.
        if (i_stall && (stall_cnt < STALL_LIM)) begin
          stall_cnt_n = stall_cnt + 1'b1;
        end else if (wait_cnt != 4'd0) begin
          wait_cnt_n  = wait_cnt - 4'd1;
          stall_cnt_n = '0;
        end else begin
          state_n = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Memory is written only on the RESP entry edge, so an aborted request never lands.
  always_ff @(posedge i_clk) begin
    if (commit && wr_q && in_range_q) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_arvi_mem_responder.sv
// tb/tb_arvi_mem_responder.sv - scoreboard bench for arvi_mem_responder at LATENCY 1, 2 and 0
module tb_arvi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_en [3];
  logic        wr_en  [3];
  logic        stall  [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  be     [3];
  logic        ack    [3];
  logic [31:0] rdata  [3];
  logic        err    [3];
  logic        busy   [3];

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        err;
    int          ack_cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    arvi_mem_responder #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(256),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 0)), .MAX_STALL(7)
    ) u_dut (
      .i_clk(clk), .i_rst(rst_n), .i_bus_en(bus_en[g]), .i_wr_en(wr_en[g]),
      .i_addr(addr[g]), .i_wr_data(wdata[g]), .i_byte_en(be[g]), .i_stall(stall[g]),
      .o_ack(ack[g]), .o_rd_data(rdata[g]), .o_err(err[g]), .o_busy(busy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every ack pulse pops the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ack[k] === 1'b1) begin
        exp_t e;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ack inst %0d at cycle %0d: got ack with empty queue, required none", k, cyc);
        end else begin
          e = sb.pop_front();
          check("ack_inst", k, e.inst);
          check("rd_data", rdata[k], e.data);
          check("err", err[k], e.err);
          check("ack_cycle", cyc, e.ack_cyc);
        end
      end
    end
  end

  task automatic req(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e,
                     input int lat, input bit hold);
    exp_t e;
    int   t0;
    bit   got;
    t0 = cyc;
    bus_en[k] = 1'b1; wr_en[k] = wr; addr[k] = a; wdata[k] = d; be[k] = b;
    e.inst = k; e.data = exp_d; e.err = exp_e; e.ack_cyc = t0 + lat;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (ack[k] === 1'b1) got = 1'b1;
      else if (cyc > t0) check("busy_before_ack", busy[k], 1);
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL ack_timeout inst %0d addr %h: got no ack in 64 cycles, required ack", k, a);
    end
    @(posedge clk); #1;
    if (!hold) bus_en[k] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      bus_en[k] = 0; wr_en[k] = 0; stall[k] = 0; addr[k] = 0; wdata[k] = 0; be[k] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", ack[0], 0);
    check("reset_rd_data", rdata[0], 0);
    check("reset_err", err[0], 0);
    check("reset_busy", busy[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write/read, partial write, byte_en=0 write
    req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        0, 3, 0);
    req(0, 0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0, 3, 0);
    req(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0,        0, 3, 0);
    req(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0,        0, 3, 0);
    req(0, 0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD, 0, 3, 0);
    req(0, 1, 32'h10, 32'h12345678, 4'h0, 32'h0,        0, 3, 0);
    req(0, 0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0, 3, 0);

    // Range boundary: last word, first out-of-range word, alias check at word 0
    req(0, 1, 32'h0,   32'h01020304, 4'hF, 32'h0,        0, 3, 0);
    req(0, 1, 32'h3FC, 32'hA5A55A5A, 4'hF, 32'h0,        0, 3, 0);
    req(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1, 3, 0);
    req(0, 0, 32'h400, 32'h0,        4'h0, 32'h0,        1, 3, 0);
    req(0, 0, 32'h3FC, 32'h0,        4'h0, 32'hA5A55A5A, 0, 3, 0);
    req(0, 0, 32'h0,   32'h0,        4'h0, 32'h01020304, 0, 3, 0);

    // Reset in WAIT aborts the write
    req(0, 1, 32'h30, 32'h0, 4'hF, 32'h0, 0, 3, 0);
    bus_en[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_en[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_ack", ack[0], 0);
      check("rst_mid_rd_data", rdata[0], 0);
      check("rst_mid_err", err[0], 0);
      check("rst_mid_busy", busy[0], 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    req(0, 0, 32'h30, 32'h0, 4'h0, 32'h0, 0, 3, 0);

    // Stall held 20 cycles at LATENCY=2, MAX_STALL=7: forced progress gives ack in cycle 21
    req(1, 1, 32'h8, 32'h55AA00FF, 4'hF, 32'h0, 0, 4, 0);
    fork
      begin
        stall[1] = 1'b1;
        repeat (20) @(posedge clk);
        #1 stall[1] = 1'b0;
      end
    join_none
    req(1, 0, 32'h8, 32'h0, 4'h0, 32'h55AA00FF, 0, 21, 0);

    // Back-to-back reads with bus_en held at LATENCY=0
    req(2, 1, 32'h0, 32'h100, 4'hF, 32'h0, 0, 2, 0);
    req(2, 1, 32'h4, 32'h201, 4'hF, 32'h0, 0, 2, 0);
    req(2, 1, 32'h8, 32'h302, 4'hF, 32'h0, 0, 2, 0);
    req(2, 1, 32'hC, 32'h403, 4'hF, 32'h0, 0, 2, 0);
    req(2, 0, 32'h0, 32'h0, 4'h0, 32'h100, 0, 2, 1);
    req(2, 0, 32'h4, 32'h0, 4'h0, 32'h201, 0, 2, 1);
    req(2, 0, 32'h8, 32'h0, 4'h0, 32'h302, 0, 2, 1);
    req(2, 0, 32'hC, 32'h0, 4'h0, 32'h403, 0, 2, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
